// File: rtl/timer_tick_scheduler_pkg.sv
// timer_tick_scheduler_pkg
//   Shared types and constants for timer_tick_scheduler: FSM state encoding,
//   interval-timer register map, control-register bit positions and the
//   per-state bus command decode used to drive the timer's Avalon-MM port.
package timer_tick_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_W_STOP, ST_W_PL, ST_W_PH, ST_W_CLR0, ST_W_CTRL,
    ST_RUN, ST_CLR, ST_TICK, ST_S_STOP, ST_S_CLR,
    ST_SN_W, ST_SN_RL, ST_SN_RH, ST_SN_DONE
  } state_e;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;
  localparam logic [2:0] TMR_SNAPL   = 3'd4;
  localparam logic [2:0] TMR_SNAPH   = 3'd5;

  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  localparam logic [15:0] CTRL_RUN  = 16'((1 << START) | (1 << CONT) | (1 << ITO));
  localparam logic [15:0] CTRL_STOP = 16'(1 << STOP);

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_cmd_t;

  // Bus command presented while in state s. Snapshot states are decoded
  // unconditionally; they are simply unreachable when the feature is off.
  function automatic bus_cmd_t state_cmd(input state_e s, input logic [31:0] per);
    bus_cmd_t c;
    c = '0;
    case (s)
      ST_W_STOP, ST_S_STOP:        c = '{1'b1, 1'b1, TMR_CONTROL, CTRL_STOP};
      ST_W_PL:                     c = '{1'b1, 1'b1, TMR_PERIODL, per[15:0]};
      ST_W_PH:                     c = '{1'b1, 1'b1, TMR_PERIODH, per[31:16]};
      ST_W_CLR0, ST_CLR, ST_S_CLR: c = '{1'b1, 1'b1, TMR_STATUS, 16'h0000};
      ST_W_CTRL:                   c = '{1'b1, 1'b1, TMR_CONTROL, CTRL_RUN};
      ST_SN_W:                     c = '{1'b1, 1'b1, TMR_SNAPL, 16'h0000};
      ST_SN_RL:                    c = '{1'b1, 1'b0, TMR_SNAPL, 16'h0000};
      ST_SN_RH:                    c = '{1'b1, 1'b0, TMR_SNAPH, 16'h0000};
      default:                     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/timer_tick_scheduler_tick_channel.sv
// tick_channel
//   One software down-counter driven by the shared hardware tick.
//   Ports: clk, reset_n (async low), i_enable (level), i_load (reload value),
//          i_tick (one-cycle tick strobe), o_expire (one-cycle expiry pulse).
module tick_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_load,
  input  logic             i_tick,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;
  logic             r_en_d;
  logic             r_expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_en_d   <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_en_d   <= i_enable;
      r_expire <= 1'b0;
      // Disabled channels track the reload value; the enable rising edge
      // therefore also loads it.
      if (!i_enable || !r_en_d) begin
        r_count <= i_load;
      end else if (i_tick) begin
        // Testing <= 1 makes a reload of 0 behave as 1: expire every tick.
        if (r_count <= CNT_W'(1)) begin
          r_expire <= 1'b1;
          r_count  <= i_load;
        end else begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  assign o_expire = r_expire;

endmodule

// File: rtl/timer_tick_scheduler.sv
// timer_tick_scheduler
//   Avalon-MM master owning one interval timer. Programs and starts the
//   timer on i_start, clears status on every irq and fans each tick out to
//   NUM_CH tick_channel down-counters. i_stop stops the timer.
//   Optional: define TIMER_TICK_SCHEDULER_SNAPSHOT_EN to enable counter
//   snapshots via i_snap_req / o_snap_valid / o_snap_value.
//   Ports: clk, reset_n (async low); i_start, i_stop, i_period; i_ch_enable,
//          i_ch_load, o_ch_expire; o_running, o_tick_count; i_snap_req,
//          o_snap_valid, o_snap_value; o_tmr_* / i_tmr_* timer bus and irq.
module timer_tick_scheduler
  import timer_tick_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [31:0]             i_period,
  input  logic [NUM_CH-1:0]       i_ch_enable,
  input  logic [NUM_CH*CNT_W-1:0] i_ch_load,
  output logic [NUM_CH-1:0]       o_ch_expire,
  output logic                    o_running,
  output logic [31:0]             o_tick_count,
  input  logic                    i_snap_req,
  output logic                    o_snap_valid,
  output logic [31:0]             o_snap_value,
  output logic [2:0]              o_tmr_address,
  output logic                    o_tmr_chipselect,
  output logic                    o_tmr_write_n,
  output logic [15:0]             o_tmr_writedata,
  input  logic [15:0]             i_tmr_readdata,
  input  logic                    i_tmr_irq
);

  state_e    r_state, w_next;
  bus_cmd_t  r_cmd, w_cmd;
  logic [31:0] r_period;
  logic [31:0] r_tick_count;
  logic        r_stop_pend;
  logic        w_stop_any;
  logic        w_snap_any;
  logic        w_tick;

  // A stop arriving in the same cycle it is acted on must still win.
  assign w_stop_any = r_stop_pend | i_stop;

`ifdef TIMER_TICK_SCHEDULER_SNAPSHOT_EN
  logic        r_snap_pend;
  logic        r_snap_valid;
  logic [15:0] r_snap_lo;
  logic [31:0] r_snap_value;
  assign w_snap_any = r_snap_pend | i_snap_req;
`else
  assign w_snap_any = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (i_start) w_next = ST_W_STOP;
      ST_W_STOP:  w_next = ST_W_PL;
      ST_W_PL:    w_next = ST_W_PH;
      ST_W_PH:    w_next = ST_W_CLR0;
      ST_W_CTRL:  w_next = w_stop_any ? ST_S_STOP : ST_RUN;
      ST_W_CLR0:  w_next = ST_W_CTRL;
      ST_RUN: begin
        if (w_stop_any)     w_next = ST_S_STOP;
        else if (i_tmr_irq) w_next = ST_CLR;
        else if (w_snap_any) w_next = ST_SN_W;
      end
      ST_CLR:     w_next = ST_TICK;
      // Bus-idle cycle: irq has dropped by the time RUN samples it again.
      ST_TICK:    w_next = ST_RUN;
      ST_S_STOP:  w_next = ST_S_CLR;
      ST_S_CLR:   w_next = ST_IDLE;
      ST_SN_W:    w_next = ST_SN_RL;
      ST_SN_RL:   w_next = ST_SN_RH;
      ST_SN_RH:   w_next = ST_SN_DONE;
      ST_SN_DONE: w_next = ST_RUN;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they are valid in the
  // cycle the state is entered.
  assign w_cmd = state_cmd(w_next, r_period);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cmd        <= '0;
      r_period     <= '0;
      r_tick_count <= '0;
      r_stop_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cmd   <= w_cmd;
      if (r_state == ST_IDLE && i_start) begin
        r_period     <= i_period;
        r_tick_count <= '0;
      end else if (r_state == ST_TICK) begin
        r_tick_count <= r_tick_count + 32'd1;
      end
      if (w_next == ST_IDLE)                  r_stop_pend <= 1'b0;
      else if (i_stop && r_state != ST_IDLE)  r_stop_pend <= 1'b1;
    end
  end

`ifdef TIMER_TICK_SCHEDULER_SNAPSHOT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_pend  <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_lo    <= '0;
      r_snap_value <= '0;
    end else begin
      if (w_next == ST_SN_W || w_next == ST_IDLE)  r_snap_pend <= 1'b0;
      else if (i_snap_req && r_state != ST_IDLE)   r_snap_pend <= 1'b1;
      // readdata lags the address by one cycle: low half arrives in SN_RH,
      // high half in SN_DONE.
      if (r_state == ST_SN_RH) r_snap_lo <= i_tmr_readdata;
      if (r_state == ST_SN_DONE) r_snap_value <= {i_tmr_readdata, r_snap_lo};
      r_snap_valid <= (r_state == ST_SN_DONE);
    end
  end
  assign o_snap_valid = r_snap_valid;
  assign o_snap_value = r_snap_value;
`else
  logic w_unused_snap;
  assign w_unused_snap = ^{i_tmr_readdata, i_snap_req};
  assign o_snap_valid  = 1'b0;
  assign o_snap_value  = '0;
`endif

  assign w_tick = (r_state == ST_TICK);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_enable (i_ch_enable[g]),
      .i_load   (i_ch_load[g*CNT_W +: CNT_W]),
      .i_tick   (w_tick),
      .o_expire (o_ch_expire[g])
    );
  end

  assign o_running = (r_state inside {ST_RUN, ST_TICK, ST_CLR,
                                      ST_SN_W, ST_SN_RL, ST_SN_RH, ST_SN_DONE});
  assign o_tick_count     = r_tick_count;
  assign o_tmr_address    = r_cmd.addr;
  assign o_tmr_chipselect = r_cmd.cs;
  assign o_tmr_write_n    = ~r_cmd.wr;
  assign o_tmr_writedata  = r_cmd.data;

endmodule
